// File: rtl/mem_responder.sv
// mem_responder: IMEM/DMEM responder that holds the core in clear while a program streams into IMEM.
// Define MEM_RESP_STATS_EN to add saturating RUN-state read/write access counters.
module mem_responder #(
   parameter int DATA_SIZE = 32,
   parameter int ADDR_SIZE = 10
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [ADDR_SIZE-1:0] iaddr,
   output logic [DATA_SIZE-1:0] idata,
   input  logic [ADDR_SIZE-1:0] daddr,
   input  logic [DATA_SIZE-1:0] ddata_w,
   output logic [DATA_SIZE-1:0] ddata_r,
   input  logic                 mem_write,
   input  logic                 mem_read,
   input  logic                 load_valid,
   input  logic [DATA_SIZE-1:0] load_data,
   input  logic                 load_last,
   output logic                 load_ready,
   input  logic                 reload,
   output logic                 core_hold,
`ifdef MEM_RESP_STATS_EN
   output logic [15:0]          read_count,
   output logic [15:0]          write_count,
`endif
   output logic [ADDR_SIZE:0]   words_loaded
);
   typedef enum logic [1:0] {LOAD, SETTLE, RUN} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
   logic [ADDR_SIZE:0]     words_q, words_d;
   logic                   accept, run;
   logic [DATA_SIZE-1:0]   imem [2**ADDR_SIZE];
   logic [DATA_SIZE-1:0]   dmem [2**ADDR_SIZE];

   // reload wins over a word offered in the same cycle, so that word is never accepted
   assign accept       = load_valid && state_q == LOAD && !reload;
   assign run          = state_q == RUN;
   assign load_ready   = state_q == LOAD;
   assign core_hold    = !run;
   assign words_loaded = words_q;
   assign idata        = imem[iaddr];
   assign ddata_r      = mem_read ? dmem[daddr] : '0;

   always_comb begin
      state_d = reload ? LOAD
              : state_q == LOAD ? ((accept && (load_last || &ptr_q)) ? SETTLE : LOAD)
              : RUN;
      ptr_d   = reload ? '0 : accept ? ptr_q + 1'b1 : ptr_q;
      words_d = reload ? '0 : accept ? words_q + 1'b1 : words_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= LOAD;
         ptr_q   <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         words_q <= words_d;
      end
   end

   // Memories are deliberately not reset
   always_ff @(posedge CLK) begin
      if (accept) imem[ptr_q] <= load_data;
      if (mem_write && run) dmem[daddr] <= ddata_w;
   end

`ifdef MEM_RESP_STATS_EN
   logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;

   always_comb begin
      rd_cnt_d = reload ? '0 : (run && mem_read && !(&rd_cnt_q)) ? rd_cnt_q + 16'd1 : rd_cnt_q;
      wr_cnt_d = reload ? '0 : (run && mem_write && !(&wr_cnt_q)) ? wr_cnt_q + 16'd1 : wr_cnt_q;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else begin
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
      end
   end

   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder against a queue/array reference model.
module tb_mem_responder;
   localparam int DW = 32;
   localparam int AW = 10;
   localparam int WW = AW + 1;
   localparam int DEPTH = 1 << AW;

   logic          CLK = 0, RESET = 1;
   logic [AW-1:0] iaddr = '0, daddr = '0;
   logic [DW-1:0] idata, ddata_r, ddata_w = '0, load_data = '0;
   logic          mem_write = 0, mem_read = 0, load_valid = 0, load_last = 0, reload = 0;
   logic          load_ready, core_hold;
   logic [WW-1:0] words_loaded;
`ifdef MEM_RESP_STATS_EN
   logic [15:0]   read_count, write_count;
`endif

   mem_responder #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
      .CLK(CLK), .RESET(RESET), .iaddr(iaddr), .idata(idata), .daddr(daddr),
      .ddata_w(ddata_w), .ddata_r(ddata_r), .mem_write(mem_write), .mem_read(mem_read),
      .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
      .load_ready(load_ready), .reload(reload), .core_hold(core_hold),
`ifdef MEM_RESP_STATS_EN
      .read_count(read_count), .write_count(write_count),
`endif
      .words_loaded(words_loaded)
   );

   always #5 CLK = ~CLK;

   int compared = 0, mismatched = 0;
   int rd_m = 0, wr_m = 0;
   logic [DW-1:0] prog [DEPTH];
   logic [DW-1:0] imem_m [DEPTH];
   logic [DW-1:0] dmem_m [int];

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic check_stats(input string tag);
`ifdef MEM_RESP_STATS_EN
      compared++;
      if (read_count !== 16'(rd_m) || write_count !== 16'(wr_m)) begin
         mismatched++;
         $display("FAIL %s_stats: read/write=%0d/%0d required %0d/%0d", tag, read_count, write_count, rd_m, wr_m);
      end
`endif
   endtask

   task automatic load_prog(input int n, input bit use_last, input int pause_at);
      int i = 0, guard = 0;
      bit paused = 0, v;
      while (i < n && guard < 8 * n + 100) begin
         guard++;
         if (i == pause_at && !paused) begin
            paused = 1;
            load_valid = 0;
            for (int k = 0; k < 10; k++) begin
               step;
               compared++;
               if (words_loaded !== WW'(i) || {core_hold, load_ready} !== 2'b11) begin
                  mismatched++;
                  $display("FAIL pause: words=%0d hold/ready=%b%b required %0d 11", words_loaded, core_hold, load_ready, i);
               end
            end
         end
         v = $urandom_range(3) != 0;
         load_valid = v;
         load_data = prog[i];
         load_last = use_last && i == n - 1;
         compared++;
         if (load_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_in_load: load_ready=%b required 1", load_ready);
         end
         step;
         if (v) begin
            imem_m[i] = prog[i];
            i++;
         end
         compared++;
         if (words_loaded !== WW'(i)) begin
            mismatched++;
            $display("FAIL words_loaded: got %0d required %0d", words_loaded, i);
         end
         if (i < n) begin
            compared++;
            if ({core_hold, load_ready} !== 2'b11) begin
               mismatched++;
               $display("FAIL stay_load: hold/ready=%b%b required 11", core_hold, load_ready);
            end
         end
      end
      if (i < n) begin
         mismatched++;
         $display("FAIL load_timeout: loaded %0d of %0d", i, n);
      end
      load_valid = 0;
      load_last = 0;
      compared++;
      if ({core_hold, load_ready} !== 2'b10) begin
         mismatched++;
         $display("FAIL settle: hold/ready=%b%b required 10", core_hold, load_ready);
      end
      step;
      compared++;
      if ({core_hold, load_ready} !== 2'b00 || words_loaded !== WW'(n)) begin
         mismatched++;
         $display("FAIL run_entry: hold/ready=%b%b words=%0d required 00 %0d", core_hold, load_ready, words_loaded, n);
      end
   endtask

   task automatic check_imem(input int n, input int k);
      for (int j = 0; j < k; j++) begin
         int a;
         a = $urandom_range(n - 1);
         iaddr = AW'(a);
         #1;
         compared++;
         if (idata !== imem_m[a]) begin
            mismatched++;
            $display("FAIL idata[%0d]: got %h required %h", a, idata, imem_m[a]);
         end
      end
   endtask

   task automatic run_cycle(input bit rd, input bit wr, input int addr, input logic [DW-1:0] data);
      logic [DW-1:0] exp;
      mem_read = rd;
      mem_write = wr;
      daddr = AW'(addr);
      ddata_w = data;
      #1;
      if (!rd || dmem_m.exists(addr)) begin
         exp = rd ? dmem_m[addr] : '0;
         compared++;
         if (ddata_r !== exp) begin
            mismatched++;
            $display("FAIL ddata_r[%0d] rd=%b: got %h required %h", addr, rd, ddata_r, exp);
         end
      end
      step;
      if (wr) dmem_m[addr] = data;
      if (rd && rd_m < 65535) rd_m++;
      if (wr && wr_m < 65535) wr_m++;
      mem_read = 0;
      mem_write = 0;
   endtask

   task automatic do_reload(input bit with_word);
      reload = 1;
      load_valid = with_word;
      load_data = $urandom;
      step;
      reload = 0;
      load_valid = 0;
      rd_m = 0;
      wr_m = 0;
      compared++;
      if ({core_hold, load_ready} !== 2'b11 || words_loaded !== '0) begin
         mismatched++;
         $display("FAIL reload: hold/ready=%b%b words=%0d required 11 0", core_hold, load_ready, words_loaded);
      end
      check_stats("reload");
   endtask

   task automatic test_reset;
      RESET = 1;
      #3;
      compared++;
      if ({core_hold, load_ready} !== 2'b11 || words_loaded !== '0) begin
         mismatched++;
         $display("FAIL reset: hold/ready=%b%b words=%0d required 11 0", core_hold, load_ready, words_loaded);
      end
      check_stats("reset");
      step;
      RESET = 0;
      step;
   endtask

   task automatic test_load_program;
      prog[0] = 32'h00500093;
      prog[1] = 32'h00100113;
      prog[2] = 32'h002081B3;
      prog[3] = 32'h0000006F;
      load_prog(4, 1, 2);
      iaddr = 2;
      #1;
      compared++;
      if (idata !== 32'h002081B3) begin
         mismatched++;
         $display("FAIL idata_2: got %h required 002081b3", idata);
      end
      check_imem(4, 6);
   endtask

   task automatic test_dmem;
      for (int a = 0; a < 16; a++) run_cycle(0, 1, a, $urandom);
      run_cycle(1, 1, 5, 32'hDEADBEEF);
      mem_read = 1;
      daddr = 5;
      #1;
      compared++;
      if (ddata_r !== 32'hDEADBEEF) begin
         mismatched++;
         $display("FAIL raw_next: got %h required deadbeef", ddata_r);
      end
      mem_read = 0;
      run_cycle(0, 0, 5, '0);
      for (int j = 0; j < 60; j++)
         run_cycle(1'($urandom), 1'($urandom), $urandom_range(15), $urandom);
      check_stats("run");
   endtask

   task automatic test_reload_and_load_write;
      do_reload(1);
      mem_write = 1;
      daddr = 3;
      ddata_w = 32'h1234;
      step;
      mem_write = 0;
      for (int j = 0; j < 4; j++) prog[j] = $urandom;
      load_prog(4, 1, -1);
      check_imem(4, 6);
      run_cycle(1, 0, 3, '0);
   endtask

   task automatic test_full_load;
      do_reload(0);
      for (int j = 0; j < DEPTH; j++) prog[j] = $urandom;
      load_prog(DEPTH, 0, -1);
      check_imem(DEPTH, 16);
   endtask

   task automatic test_reset_midload;
      for (int j = 0; j < 5; j++) run_cycle(1, 1, $urandom_range(15), $urandom);
      do_reload(0);
      load_valid = 1;
      load_data = $urandom;
      step;
      step;
      #2;
      RESET = 1;
      rd_m = 0;
      wr_m = 0;
      #1;
      compared++;
      if ({core_hold, load_ready} !== 2'b11 || words_loaded !== '0) begin
         mismatched++;
         $display("FAIL reset_midload: hold/ready=%b%b words=%0d required 11 0", core_hold, load_ready, words_loaded);
      end
      load_valid = 0;
      step;
      RESET = 0;
      for (int j = 0; j < 4; j++) prog[j] = $urandom;
      load_prog(4, 1, -1);
      check_imem(4, 4);
      for (int j = 0; j < 6; j++) run_cycle(1, 1, $urandom_range(15), $urandom);
      check_stats("before_reset");
      #2;
      RESET = 1;
      rd_m = 0;
      wr_m = 0;
      #1;
      compared++;
      if ({core_hold, load_ready} !== 2'b11) begin
         mismatched++;
         $display("FAIL reset_in_run: hold/ready=%b%b required 11", core_hold, load_ready);
      end
      check_stats("reset_in_run");
      step;
      RESET = 0;
   endtask

   initial begin
      test_reset;
      test_load_program;
      test_dmem;
      test_reload_and_load_write;
      test_full_load;
      test_reset_midload;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
